// File: rtl/echo_pulse_sequencer.sv
// ---------------------------------------------------------------------------
// echo_pulse_sequencer
//
// RF gate sequencer for spin-echo, Ramsey and CPMG experiments. One trigger
// produces the gate pattern
//   pi/2 - [tau - pi] x N - tau - pi/2
// on the rf output. Pulse and interval lengths and the pi-pulse count are
// sampled at the accepted trigger. Later changes to these inputs do not
// affect a run that is already in progress.
//
// Parameters
//   CNT_W : width of the duration inputs and of the internal down-counter
//   NPI_W : width of the pi-pulse count (up to 2^NPI_W-1 pi pulses)
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active high
//   trig       : start request, sampled on each rising edge while idle
//   abort      : synchronous stop; a running sequence returns to idle
//   t_pi2      : pi/2 pulse length in cycles (0 is treated as 1)
//   t_pi       : pi pulse length in cycles (0 is treated as 1)
//   t_tau      : interval length in cycles (0 is treated as 1)
//   n_pi       : number of pi pulses (0 gives a Ramsey sequence)
//   rf         : RF gate, high during pulses
//   pulse_type : 0 none, 1 pi/2, 2 pi
//   pi_count   : pi pulses completed in the current or last run
//   busy       : sequence in progress
//   done       : one-cycle completion strobe
//
// Every output is a flop. The next-state logic also computes the next output
// values, so each output becomes valid on the same edge as the state change.
// ---------------------------------------------------------------------------
module echo_pulse_sequencer #(
  parameter int CNT_W = 16,
  parameter int NPI_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             abort,
  input  logic [CNT_W-1:0] t_pi2,
  input  logic [CNT_W-1:0] t_pi,
  input  logic [CNT_W-1:0] t_tau,
  input  logic [NPI_W-1:0] n_pi,
  output logic             rf,
  output logic [1:0]       pulse_type,
  output logic [NPI_W-1:0] pi_count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PI2_A = 3'd1,
    S_GAP   = 3'd2,
    S_PI    = 3'd3,
    S_PI2_B = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  localparam logic [1:0] PT_NONE = 2'd0;
  localparam logic [1:0] PT_PI2  = 2'd1;
  localparam logic [1:0] PT_PI   = 2'd2;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NPI_W-1:0] pic_d;

  // Configuration captured at the accepted trigger.
  logic [CNT_W-1:0] cfg_pi2, cfg_pi, cfg_tau;
  logic [NPI_W-1:0] cfg_npi;
  logic             latch_en;

  logic             rf_d;
  logic [1:0]       pt_d;
  logic             busy_d;
  logic             done_d;
  logic             running;

  // The counter is loaded with duration-1 when a state is entered. The state
  // is left when the counter reads zero. A zero duration uses a load of 0, so
  // the state lasts one cycle.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] dur);
    return (dur == '0) ? '0 : (dur - CNT_W'(1));
  endfunction

  // Abort is honoured only in the timed states. FIN already goes to IDLE,
  // and in IDLE abort only masks trig.
  assign running = (state_q != S_IDLE) && (state_q != S_FIN);

  // Next-state and counter logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pic_d    = pi_count;
    latch_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trig && !abort) begin
          state_d  = S_PI2_A;
          cnt_d    = load_val(t_pi2);
          pic_d    = '0;
          latch_en = 1'b1;
        end
      end

      S_PI2_A: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = load_val(cfg_tau);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          if (pi_count < cfg_npi) begin
            state_d = S_PI;
            cnt_d   = load_val(cfg_pi);
          end else begin
            state_d = S_PI2_B;
            cnt_d   = load_val(cfg_pi2);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_PI: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = load_val(cfg_tau);
          pic_d   = pi_count + NPI_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_PI2_B: begin
        if (cnt_q == '0) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort && running) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pic_d   = '0;
    end
  end

  // Output decode from the next state, so the output flops and the state
  // register change on the same edge.
  always_comb begin
    rf_d   = 1'b0;
    pt_d   = PT_NONE;
    busy_d = 1'b0;
    done_d = 1'b0;

    case (state_d)
      S_PI2_A, S_PI2_B: begin
        rf_d   = 1'b1;
        pt_d   = PT_PI2;
        busy_d = 1'b1;
      end
      S_PI: begin
        rf_d   = 1'b1;
        pt_d   = PT_PI;
        busy_d = 1'b1;
      end
      S_GAP: begin
        busy_d = 1'b1;
      end
      S_FIN: begin
        done_d = 1'b1;
      end
      default: begin
        rf_d = 1'b0;
      end
    endcase
  end

  // Registered state, counter, configuration and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_pi2    <= '0;
      cfg_pi     <= '0;
      cfg_tau    <= '0;
      cfg_npi    <= '0;
      pi_count   <= '0;
      rf         <= 1'b0;
      pulse_type <= PT_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pi_count   <= pic_d;
      rf         <= rf_d;
      pulse_type <= pt_d;
      busy       <= busy_d;
      done       <= done_d;
      if (latch_en) begin
        cfg_pi2 <= t_pi2;
        cfg_pi  <= t_pi;
        cfg_tau <= t_tau;
        cfg_npi <= n_pi;
      end
    end
  end

endmodule

// File: tb/tb_echo_pulse_sequencer.sv
module tb_echo_pulse_sequencer;

  localparam int CNT_W = 16;
  localparam int NPI_W = 4;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             trig  = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] t_pi2 = '0;
  logic [CNT_W-1:0] t_pi  = '0;
  logic [CNT_W-1:0] t_tau = '0;
  logic [NPI_W-1:0] n_pi  = '0;
  logic             rf;
  logic [1:0]       pulse_type;
  logic [NPI_W-1:0] pi_count;
  logic             busy;
  logic             done;

  echo_pulse_sequencer #(.CNT_W(CNT_W), .NPI_W(NPI_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .abort      (abort),
    .t_pi2      (t_pi2),
    .t_pi       (t_pi),
    .t_tau      (t_tau),
    .n_pi       (n_pi),
    .rf         (rf),
    .pulse_type (pulse_type),
    .pi_count   (pi_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rf;
    logic [1:0] pt;
    logic       busy;
    logic       done;
    int         pic;
  } exp_t;

  typedef struct {
    int    p2;
    int    pi;
    int    tau;
    int    npi;
    int    exp_busy;
    int    exp_done;
    string name;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  vec_t vecs[6];

  task automatic compare(input string tag, input exp_t e);
    checks++;
    if (rf !== e.rf || pulse_type !== e.pt || busy !== e.busy ||
        done !== e.done || pi_count !== NPI_W'(e.pic)) begin
      failures++;
      $display("FAIL %s cyc=%0d got rf=%b pt=%0d busy=%b done=%b pic=%0d expected rf=%b pt=%0d busy=%b done=%b pic=%0d",
               tag, cyc, rf, pulse_type, busy, done, pi_count,
               e.rf, e.pt, e.busy, e.done, e.pic);
    end
  endtask

  task automatic compare_int(input string tag, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  // Advance one clock and check the DUT against the oldest scoreboard entry.
  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare(tag, e);
    end
  endtask

  function automatic int clampd(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic add_seg(input int n, input logic r, input logic [1:0] p, input int pic);
    for (int i = 0; i < n; i++) sb.push_back('{r, p, 1'b1, 1'b0, pic});
  endtask

  task automatic push_idle(input int n, input int pic);
    for (int i = 0; i < n; i++) sb.push_back('{1'b0, 2'd0, 1'b0, 1'b0, pic});
  endtask

  // Expected gate timeline built from the pulse/interval pattern, followed by
  // the FIN strobe and one idle cycle.
  task automatic build_trace(input int p2, input int pi, input int tau, input int npi);
    int pic;
    pic = 0;
    add_seg(clampd(p2), 1'b1, 2'd1, pic);
    for (int i = 0; i < npi; i++) begin
      add_seg(clampd(tau), 1'b0, 2'd0, pic);
      add_seg(clampd(pi), 1'b1, 2'd2, pic);
      pic++;
    end
    add_seg(clampd(tau), 1'b0, 2'd0, pic);
    add_seg(clampd(p2), 1'b1, 2'd1, pic);
    sb.push_back('{1'b0, 2'd0, 1'b0, 1'b1, pic});
    push_idle(1, pic);
  endtask

  task automatic drive_cfg(input vec_t v);
    t_pi2 = CNT_W'(v.p2);
    t_pi  = CNT_W'(v.pi);
    t_tau = CNT_W'(v.tau);
    n_pi  = NPI_W'(v.npi);
  endtask

  task automatic run_full(input vec_t v);
    int nb, dc, total;
    drive_cfg(v);
    trig = 1'b1;
    build_trace(v.p2, v.pi, v.tau, v.npi);
    total = sb.size();
    nb = 0;
    dc = -1;
    for (int c = 0; c < total; c++) begin
      cyc = c;
      step(v.name);
      if (busy === 1'b1) nb++;
      if (done === 1'b1 && dc < 0) dc = c;
      if (c == 0) begin
        trig  = 1'b0;
        t_pi2 = CNT_W'($urandom);
        t_pi  = CNT_W'($urandom);
        t_tau = CNT_W'($urandom);
        n_pi  = NPI_W'($urandom);
      end
      if (c == 1 && v.exp_busy >= 3) trig = 1'b1;
      if (c == 2) trig = 1'b0;
    end
    compare_int({v.name, "_busy_cycles"}, nb, v.exp_busy);
    compare_int({v.name, "_done_cycle"}, dc, v.exp_done);
  endtask

  task automatic run_abort(input vec_t v, input int acyc);
    int ndone;
    drive_cfg(v);
    trig = 1'b1;
    build_trace(v.p2, v.pi, v.tau, v.npi);
    for (int c = 0; c <= acyc; c++) begin
      cyc = c;
      step({v.name, "_pre_abort"});
      if (c == 0) trig = 1'b0;
    end
    abort = 1'b1;
    sb.delete();
    push_idle(40, 0);
    ndone = 0;
    for (int c = acyc + 1; c < acyc + 41; c++) begin
      cyc = c;
      step({v.name, "_post_abort"});
      abort = 1'b0;
      if (done === 1'b1) ndone++;
    end
    compare_int({v.name, "_abort_done_count"}, ndone, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10, 20, 20, 1, 80, 80, "spin_echo"};
    vecs[1] = '{4, 9, 6, 0, 14, 14, "ramsey"};
    vecs[2] = '{2, 4, 3, 3, 28, 28, "cpmg"};
    vecs[3] = '{0, 0, 0, 1, 5, 5, "zero_dur"};
    vecs[4] = '{1, 1, 1, 15, 33, 33, "max_npi"};
    vecs[5] = '{3, 0, 2, 2, 14, 14, "zero_pi"};

    // Reset state, then quiet idle after release.
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    compare("reset_state", '{1'b0, 2'd0, 1'b0, 1'b0, 0});
    #3 rst = 1'b0;
    push_idle(4, 0);
    repeat (4) step("idle_after_reset");

    // abort in IDLE masks trig.
    trig  = 1'b1;
    abort = 1'b1;
    push_idle(1, 0);
    step("abort_blocks_trig");
    trig  = 1'b0;
    abort = 1'b0;
    push_idle(3, 0);
    repeat (3) step("abort_blocks_trig_idle");

    // Table of sequences.
    for (int i = 0; i < 6; i++) run_full(vecs[i]);

    // trig held high: FIN ignores it, the following idle cycle accepts it.
    t_pi2 = '0;
    t_pi  = '0;
    t_tau = '0;
    n_pi  = NPI_W'(1);
    trig  = 1'b1;
    build_trace(0, 0, 0, 1);
    build_trace(0, 0, 0, 1);
    for (int c = 0; c < 14; c++) begin
      cyc = c;
      step("trig_held");
      if (c == 8) trig = 1'b0;
    end

    // Abort mid-run, then a fresh run with identical timing.
    run_abort(vecs[0], 35);
    run_full(vecs[0]);
    run_abort(vecs[2], 20);
    run_full(vecs[2]);

    // Asynchronous reset in the middle of a pi pulse.
    drive_cfg(vecs[0]);
    trig = 1'b1;
    build_trace(10, 20, 20, 1);
    for (int c = 0; c <= 40; c++) begin
      cyc = c;
      step("pre_async_rst");
      if (c == 0) trig = 1'b0;
    end
    sb.delete();
    #2 rst = 1'b1;
    #1;
    compare("async_rst_immediate", '{1'b0, 2'd0, 1'b0, 1'b0, 0});
    #3 rst = 1'b0;
    push_idle(6, 0);
    for (int c = 0; c < 6; c++) begin
      cyc = c;
      step("after_async_rst");
    end
    run_full(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
